// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: widths, NOP encoding, fetch FSM states and the IF/ID slot layout.
// No logic here; no latency; no backpressure.
// Imported by etapa_busqueda and registro_if_id.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [ILEN-1:0] instruccion;
        logic [XLEN-1:0] pc;
    } if_id_t;

endpackage

// File: rtl/registro_if_id.sv
// IF/ID pipeline register: load, hold under stall, flush to an empty NOP slot.
// Latency: 1 edge from load to output.
// Backpressure: stall holds a valid slot; an empty slot is consumed/overwritten regardless.
module registro_if_id
    import cpu_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   load,
    input  logic   stall,
    input  if_id_t load_dat,
    output if_id_t slot
);

    if_id_t slot_q, slot_d;

    // Flush beats load; an unstalled valid slot with nothing new empties itself.
    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d.valid       = 1'b0;
            slot_d.instruccion = NOP_INSTR;
        end else if (load) begin
            slot_d = load_dat;
        end else if (slot_q.valid && !stall) begin
            slot_d.valid       = 1'b0;
            slot_d.instruccion = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '{valid: 1'b0, instruccion: NOP_INSTR, pc: '0};
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/etapa_busqueda.sv
// Fetch stage: PC, imem req/valid FSM, one-entry hold buffer, IF/ID register (IF_PERF_CNT_EN adds wait counter).
// Latency: request cycle to IF/ID 2 edges later with 1-cycle memory; 1 instruction / 2 cycles.
// Backpressure: decode stall parks one response in the hold buffer; redirect flushes and drains.
module etapa_busqueda
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET  = '0,
    parameter logic [ILEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [ILEN-1:0] imem_data,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [ILEN-1:0] id_instruccion,
    output logic [XLEN-1:0] id_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_espera_cnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    if_id_t          hold_q, hold_d;

    logic            id_load;
    if_id_t          id_load_dat;
    if_id_t          id_slot;
    if_id_t          fetched;
    logic            slot_free;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_tgt;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign slot_free    = !id_slot.valid || !stall;
    assign fetched      = '{valid: 1'b1, instruccion: imem_data, pc: pc_q};

    // FETCH with req_q=0 only happens right after reset: it raises the first request.
    // Every entry into FETCH from elsewhere issues the request on the same edge.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = 1'b0;
        addr_d      = addr_q;
        hold_d      = hold_q;
        id_load     = 1'b0;
        id_load_dat = fetched;
        if (redirect) begin
            pc_d   = redirect_tgt;
            hold_d = '0;
            if ((state_q == FETCH && req_q) || (state_q == WAIT && !imem_valid)) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = redirect_tgt;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_q) begin
                        state_d = WAIT;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        pc_d = pc_plus4;
                        if (slot_free) begin
                            id_load = 1'b1;
                            state_d = FETCH;
                            req_d   = 1'b1;
                            addr_d  = pc_plus4;
                        end else begin
                            hold_d  = fetched;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_load      = 1'b1;
                        id_load_dat  = hold_q;
                        hold_d.valid = 1'b0;
                        state_d      = FETCH;
                        req_d        = 1'b1;
                        addr_d       = pc_q;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            req_q   <= 1'b0;
            addr_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    registro_if_id #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (reset),
        .flush    (redirect),
        .load     (id_load),
        .stall    (stall),
        .load_dat (id_load_dat),
        .slot     (id_slot)
    );

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign id_valid       = id_slot.valid;
    assign id_instruccion = id_slot.instruccion;
    assign id_pc          = id_slot.pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q != FETCH && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_espera_cnt = perf_q;
`endif

endmodule

// File: tb/tb_etapa_busqueda.sv
// Directed bench for etapa_busqueda: main instance plus one with PC_RESET near the top of the address space.
module tb_etapa_busqueda;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_valid, stall, redirect;
    logic [63:0] imem_addr, redirect_pc, id_pc;
    logic [31:0] imem_data, id_instruccion;
    logic        id_valid;

    logic        imem_req5, imem_valid5, id_valid5;
    logic [63:0] imem_addr5, id_pc5;
    logic [31:0] imem_data5, id_instruccion5;
    logic        stall5, redirect5;
    logic [63:0] redirect_pc5;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf, perf5;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    etapa_busqueda dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instruccion (id_instruccion),
        .id_pc          (id_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_espera_cnt(perf)
`endif
    );

    etapa_busqueda #(
        .PC_RESET (64'hFFFF_FFFF_FFFF_FFFC)
    ) dut5 (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req5),
        .imem_addr      (imem_addr5),
        .imem_valid     (imem_valid5),
        .imem_data      (imem_data5),
        .stall          (stall5),
        .redirect       (redirect5),
        .redirect_pc    (redirect_pc5),
        .id_valid       (id_valid5),
        .id_instruccion (id_instruccion5),
        .id_pc          (id_pc5)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_espera_cnt(perf5)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        imem_valid = 1'b0; imem_data = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_valid5 = 1'b0; imem_data5 = '0; stall5 = 1'b0; redirect5 = 1'b0; redirect_pc5 = '0;
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_vld", id_valid, 0);
        chk("rst_ins", id_instruccion, NOP);
        chk("rst_pc", id_pc, 0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf", perf, 0);
`endif
        reset = 1'b0;

        // 1: first fetch, 1-cycle memory
        begin
            int n = 0;
            tick();
            while (!imem_req && n < 10) begin
                tick();
                n++;
            end
        end
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 64'h0);
        chk("t5_addr0", imem_addr5, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("t1_wait_req", imem_req, 0);
        imem_valid = 1'b1; imem_data = 32'hC631_0200;
        tick();
        imem_valid = 1'b0;
        chk("t1_vld", id_valid, 1);
        chk("t1_ins", id_instruccion, 32'hC631_0200);
        chk("t1_pc", id_pc, 0);
        chk("t1_next", imem_addr, 64'h4);
        chk("t1_next_req", imem_req, 1);
`ifdef IF_PERF_CNT_EN
        chk("t1_perf", perf, 1);
`endif

        // 2: response arrives under stall, parked, released later
        stall = 1'b1;
        tick();
        imem_valid = 1'b1; imem_data = 32'h00A0_0093;
        tick();
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_pc", id_pc, 0);
            chk("t2_hold_ins", id_instruccion, 32'hC631_0200);
            chk("t2_hold_req", imem_req, 0);
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        chk("t2_pc", id_pc, 64'h4);
        chk("t2_ins", id_instruccion, 32'h00A0_0093);
        chk("t2_vld", id_valid, 1);
        chk("t2_next", imem_addr, 64'h8);

        // 3: redirect while waiting, stale response two cycles later
        tick();
        chk("t3_consume_vld", id_valid, 0);
        chk("t3_consume_ins", id_instruccion, NOP);
        redirect = 1'b1; redirect_pc = 64'h103;
        tick();
        redirect = 1'b0;
        chk("t3_flush_vld", id_valid, 0);
        chk("t3_drain_req", imem_req, 0);
        tick();
        imem_valid = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0;
        chk("t3_stale_vld", id_valid, 0);
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 64'h100);

        // 4: redirect coincides with response
        tick();
        imem_valid = 1'b1; imem_data = 32'h1234_5678;
        redirect = 1'b1; redirect_pc = 64'h202;
        tick();
        imem_valid = 1'b0; redirect = 1'b0;
        chk("t4_vld", id_valid, 0);
        chk("t4_ins", id_instruccion, NOP);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 64'h200);

        // 5: PC wrap on the second instance (sitting in WAIT since reset)
        imem_valid5 = 1'b1; imem_data5 = 32'h0000_0517;
        tick();
        imem_valid5 = 1'b0;
        chk("t5_pc", id_pc5, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_vld", id_valid5, 1);
        chk("t5_wrap", imem_addr5, 64'h0);
        chk("t5_req", imem_req5, 1);

        // 6: async reset while in WAIT, late response afterwards
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req", imem_req, 0);
        chk("t6_vld", id_valid, 0);
        chk("t6_ins", id_instruccion, NOP);
        chk("t6_pc", id_pc, 0);
`ifdef IF_PERF_CNT_EN
        chk("t6_perf", perf, 0);
`endif
        tick();
        reset = 1'b0;
        imem_valid = 1'b1; imem_data = 32'hBAD0_BAD0;
        tick();
        imem_valid = 1'b0;
        chk("t6_late_vld", id_valid, 0);
        chk("t6_late_req", imem_req, 1);
        chk("t6_late_addr", imem_addr, 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
